// File: rtl/fetch_stage.sv
// fetch_stage: instruction fetch with one outstanding request, decode handshake, and branch/flush redirect.
module fetch_stage (
  input  logic        Clk,
  input  logic        Reset_n,
  input  logic        Stall,
  input  logic        PC_sel,
  input  logic [31:0] Immed,
  input  logic        Flush,
  input  logic [31:0] Flush_PC,
  output logic        Mem_Req,
  output logic [31:0] Mem_Addr,
  input  logic        Mem_Ack,
  input  logic [31:0] Mem_Rdata,
  output logic [31:0] Instr,
  output logic        Instr_valid,
  output logic [31:0] PC_out
);
  typedef enum logic [1:0] {IDLE, REQ, HOLD, DRAIN} state_t;
  state_t state_q, state_d;
  logic [31:0] pc_q, pc_d, addr_q, addr_d, instr_q, instr_d, pc_out_q, pc_out_d, next_pc;
  logic req_q, req_d, valid_q, valid_d, consume;
  assign consume = valid_q && !Stall;
  assign next_pc = pc_out_q + 32'd4 + (PC_sel ? {Immed[29:0], 2'b00} : 32'd0);
  always_comb begin
    state_d = state_q;
    pc_d = pc_q;
    addr_d = addr_q;
    instr_d = instr_q;
    pc_out_d = pc_out_q;
    req_d = req_q;
    valid_d = valid_q;
    case (state_q)
      IDLE: begin
        state_d = REQ;
        pc_d = Flush ? Flush_PC : pc_q;
        req_d = 1'b1;
        addr_d = pc_d;
      end
      REQ:
        if (Mem_Ack && Flush) begin
          pc_d = Flush_PC;
          addr_d = Flush_PC;
        end else if (Mem_Ack) begin
          state_d = HOLD;
          req_d = 1'b0;
          valid_d = 1'b1;
          instr_d = Mem_Rdata;
          pc_out_d = pc_q;
        end else if (Flush) begin
          state_d = DRAIN;
          pc_d = Flush_PC;
        end
      HOLD:
        if (Flush || consume) begin
          state_d = REQ;
          valid_d = 1'b0;
          req_d = 1'b1;
          pc_d = Flush ? Flush_PC : next_pc;
          addr_d = pc_d;
        end
      // the stale request keeps its address until memory answers it
      DRAIN: begin
        pc_d = Flush ? Flush_PC : pc_q;
        if (Mem_Ack) begin
          state_d = REQ;
          addr_d = pc_d;
        end
      end
    endcase
  end
  always_ff @(posedge Clk or negedge Reset_n)
    if (!Reset_n) begin
      state_q <= IDLE;
      pc_q <= '0;
      addr_q <= '0;
      instr_q <= '0;
      pc_out_q <= '0;
      req_q <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q <= pc_d;
      addr_q <= addr_d;
      instr_q <= instr_d;
      pc_out_q <= pc_out_d;
      req_q <= req_d;
      valid_q <= valid_d;
    end
  assign Mem_Req = req_q;
  assign Mem_Addr = addr_q;
  assign Instr = instr_q;
  assign Instr_valid = valid_q;
  assign PC_out = pc_out_q;
endmodule
